mm_sequencer: RTL and testbench
===============================

MM_SEQUENCER -- requirements
Module: mm_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the element width.
REQ-002 Parameter N, default 4, SHALL set the maximum matrix dimension and the index/dimension field width.
REQ-003 Parameter OUT_DATA_WIDTH, default 20, SHALL set the product-sum width.
REQ-004 Clock and reset: reset reset, asynchronous, active-high; clock clk.
REQ-005 Ports (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  async active-high reset
- start  in  1  one-cycle job start pulse
- dim_r, dim_k, dim_c  in  N each  rows of A, shared dimension, columns of B; sampled on start
- in_valid  in  1  stream element valid
- in_ready  out  1  stream element accepted when in_valid && in_ready
- in_data  in  DATA_WIDTH  signed element stream
- wr_enable  out  1  helper write strobe
- compute_enable  out  1  helper compute strobe
- idx_i, idx_j  out  N each  helper row/column index
- is_first_mat  out  1  1 = write A, 0 = write B
- match_dim  out  N  equals latched dim_k
- wr_data  out  DATA_WIDTH  helper write data
- helper_data  in  OUT_DATA_WIDTH  signed helper result, registered by the helper
- out_valid  out  1  result valid
- out_ready  in  1  result accepted when out_valid && out_ready
- out_data  out  OUT_DATA_WIDTH  signed result C[i][j]
- busy  out  1  high in every state except IDLE
- err  out  1  sticky dimension-error flag

Function
REQ-006 FSM states SHALL be IDLE, LOAD_A, LOAD_B, ISSUE, WAIT, CAPTURE, OUTPUT.
REQ-007 IDLE + start SHALL latch the dims, clear i/j, clear err, and go to LOAD_A; start outside IDLE SHALL be ignored.
REQ-008 LOAD_A SHALL accept dim_r*dim_k elements row-major (A[i][k]); LOAD_B SHALL accept dim_k*dim_c elements row-major (B[k][j]).
REQ-009 in_ready SHALL be high only in LOAD_A/LOAD_B.
REQ-010 Each accepted element SHALL produce, from the next edge, one cycle of wr_enable=1 with wr_data, idx_i, idx_j, and is_first_mat (1 in LOAD_A, 0 in LOAD_B).
REQ-011 Index walk: the column index SHALL wrap to 0 at its dim and the row index SHALL increment; after the last element of A the FSM SHALL go to LOAD_B, and after the last element of B it SHALL go to ISSUE.
REQ-012 ISSUE SHALL drive compute_enable=1 with idx_i=i and idx_j=j for exactly one cycle, then go to WAIT.
REQ-013 The FSM SHALL hold WAIT for one cycle. CAPTURE SHALL register helper_data into out_data and set out_valid (the sample is taken on the second edge after compute_enable deasserts).
REQ-014 OUTPUT SHALL hold out_valid and out_data stable until out_ready. On acceptance, C results SHALL advance row-major to ISSUE; after C[dim_r-1][dim_c-1] the FSM SHALL return to IDLE with out_valid=0.
REQ-015 wr_enable and compute_enable SHALL never be high in the same cycle.
REQ-016 match_dim SHALL equal the latched dim_k from start until the next start.
REQ-017 The block SHALL perform no arithmetic on data; out_data SHALL be helper_data bit-exact.

Reset
REQ-018 Reset, including mid-job, SHALL force IDLE and set to 0: in_ready, wr_enable, compute_enable, idx_i, idx_j, is_first_mat, match_dim, wr_data, out_valid, out_data, busy, err. Partial matrix contents SHALL be discarded with no further strobes.

Configuration
REQ-019 With MM_SEQUENCER_DIM_CHECK_EN defined, start with any dim equal to 0 or greater than N SHALL set err=1 and keep the FSM in IDLE.
REQ-020 Without MM_SEQUENCER_DIM_CHECK_EN, dims SHALL be used unchecked and err SHALL be tied 0. A dim of 0 SHALL be treated as a zero-length walk that returns to IDLE.

Verification
REQ-021 dims 2/2/2, A=[[1,0],[0,1]], B=[[1,2],[3,4]], out_ready=1 -> out_data 1,2,3,4 in order, then IDLE.
REQ-022 dims 1/1/1, A=-128, B=127 -> one output of -16256.
REQ-023 dims 4/4/4, all elements 127 -> sixteen outputs of 64516.
REQ-024 out_ready held low 5 cycles on the first result -> out_valid and out_data stay stable, and no compute_enable pulse occurs until acceptance.
REQ-025 Reset asserted after 3 of 4 A elements -> all outputs 0 and busy=0; a following 2/2/2 job completes correctly.
REQ-026 With the macro, dim_c=5 and N=4 -> err=1 and busy stays 0; without the macro -> err stays 0.

Source files
------------

// File: rtl/mm_sequencer.sv
// Matrix-multiply sequencer: streams A and B into a helper, then issues and collects C[i][j] row-major.
// Optional start-time dimension checking is enabled by defining MM_SEQUENCER_DIM_CHECK_EN.
module mm_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int N              = 4,
    parameter int OUT_DATA_WIDTH = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N-1:0]              dim_r,
    input  logic [N-1:0]              dim_k,
    input  logic [N-1:0]              dim_c,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      wr_enable,
    output logic                      compute_enable,
    output logic [N-1:0]              idx_i,
    output logic [N-1:0]              idx_j,
    output logic                      is_first_mat,
    output logic [N-1:0]              match_dim,
    output logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [OUT_DATA_WIDTH-1:0] helper_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_DATA_WIDTH-1:0] out_data,
    output logic                      busy,
    output logic                      err
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ISSUE, WAIT, CAPTURE, OUTPUT} state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t                    state_q, state_d;
    logic [N-1:0]              dim_r_q, dim_r_d, dim_k_q, dim_k_d, dim_c_q, dim_c_d;
    logic [N-1:0]              row_q, row_d, col_q, col_d;
    logic [N-1:0]              ci_q, ci_d, cj_q, cj_d;
    logic                      wr_en_q, wr_en_d, first_q, first_d;
    logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
    logic [N-1:0]              wr_i_q, wr_i_d, wr_j_q, wr_j_d;
    logic                      out_valid_q, out_valid_d;
    logic [OUT_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                      accept;

`ifdef MM_SEQUENCER_DIM_CHECK_EN
    localparam logic [N-1:0] DIM_MAX = N'(N);
    logic err_q, err_d;
    logic dims_bad;
    assign dims_bad = (dim_r == '0) || (dim_k == '0) || (dim_c == '0) ||
                      (dim_r > DIM_MAX) || (dim_k > DIM_MAX) || (dim_c > DIM_MAX);
    assign err = err_q;
`else
    logic dims_zero;
    assign dims_zero = (dim_r == '0) || (dim_k == '0) || (dim_c == '0);
    assign err = 1'b0;
`endif

    assign in_ready       = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign accept         = in_valid && in_ready;
    // The final B write drains before the compute strobe so the two never overlap.
    assign compute_enable = (state_q == ISSUE) && !wr_en_q;
    assign idx_i          = compute_enable ? ci_q : wr_i_q;
    assign idx_j          = compute_enable ? cj_q : wr_j_q;
    assign wr_enable      = wr_en_q;
    assign wr_data        = wr_data_q;
    assign is_first_mat   = first_q;
    assign match_dim      = dim_k_q;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign busy           = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        dim_r_d     = dim_r_q;
        dim_k_d     = dim_k_q;
        dim_c_d     = dim_c_q;
        row_d       = row_q;
        col_d       = col_q;
        ci_d        = ci_q;
        cj_d        = cj_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        wr_i_d      = wr_i_q;
        wr_j_d      = wr_j_q;
        first_d     = first_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef MM_SEQUENCER_DIM_CHECK_EN
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    dim_r_d = dim_r;
                    dim_k_d = dim_k;
                    dim_c_d = dim_c;
                    row_d   = '0;
                    col_d   = '0;
                    ci_d    = '0;
                    cj_d    = '0;
`ifdef MM_SEQUENCER_DIM_CHECK_EN
                    err_d   = dims_bad;
                    if (!dims_bad) state_d = LOAD_A;
`else
                    if (!dims_zero) state_d = LOAD_A;
`endif
                end
            end
            LOAD_A, LOAD_B: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = in_data;
                    wr_i_d    = row_q;
                    wr_j_d    = col_q;
                    first_d   = (state_q == LOAD_A);
                    if (col_q == ((state_q == LOAD_A) ? dim_k_q : dim_c_q) - ONE) begin
                        col_d = '0;
                        if (row_q == ((state_q == LOAD_A) ? dim_r_q : dim_k_q) - ONE) begin
                            row_d   = '0;
                            state_d = (state_q == LOAD_A) ? LOAD_B : ISSUE;
                        end else begin
                            row_d = row_q + ONE;
                        end
                    end else begin
                        col_d = col_q + ONE;
                    end
                end
            end
            ISSUE: begin
                if (!wr_en_q) state_d = WAIT;
            end
            WAIT: state_d = CAPTURE;
            CAPTURE: begin
                out_data_d  = helper_data;
                out_valid_d = 1'b1;
                state_d     = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ISSUE;
                    if (cj_q == dim_c_q - ONE) begin
                        cj_d = '0;
                        if (ci_q == dim_r_q - ONE) begin
                            ci_d    = '0;
                            state_d = IDLE;
                        end else begin
                            ci_d = ci_q + ONE;
                        end
                    end else begin
                        cj_d = cj_q + ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dim_r_q     <= '0;
            dim_k_q     <= '0;
            dim_c_q     <= '0;
            row_q       <= '0;
            col_q       <= '0;
            ci_q        <= '0;
            cj_q        <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            wr_i_q      <= '0;
            wr_j_q      <= '0;
            first_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            dim_r_q     <= dim_r_d;
            dim_k_q     <= dim_k_d;
            dim_c_q     <= dim_c_d;
            row_q       <= row_d;
            col_q       <= col_d;
            ci_q        <= ci_d;
            cj_q        <= cj_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            wr_i_q      <= wr_i_d;
            wr_j_q      <= wr_j_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef MM_SEQUENCER_DIM_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
`endif
endmodule

// File: tb/tb_mm_sequencer.sv
// Directed bench for mm_sequencer with a behavioural multiply-accumulate helper.
// Expected results are hand-computed constants per scenario.
module tb_mm_sequencer;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int OW = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  dim_r = '0, dim_k = '0, dim_c = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          wr_enable, compute_enable, is_first_mat;
    logic [N-1:0]  idx_i, idx_j, match_dim;
    logic [DW-1:0] wr_data;
    logic [OW-1:0] helper_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic          busy, err;

    int n_pass = 0;
    int n_checks = 0;
    int wr_cnt = 0;
    int cmp_cnt = 0;
    int overlap_cnt = 0;
    int elem_q[$];
    int got_q[$];
    logic signed [DW-1:0] a_mem [16][16];
    logic signed [DW-1:0] b_mem [16][16];

    mm_sequencer #(.DATA_WIDTH(DW), .N(N), .OUT_DATA_WIDTH(OW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .dim_r(dim_r), .dim_k(dim_k), .dim_c(dim_c),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr_enable(wr_enable), .compute_enable(compute_enable),
        .idx_i(idx_i), .idx_j(idx_j), .is_first_mat(is_first_mat),
        .match_dim(match_dim), .wr_data(wr_data), .helper_data(helper_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Helper: stores A/B on write strobes, registers the dot product on a compute strobe.
    always @(posedge clk) begin : helper_model
        int s;
        if (wr_enable) begin
            wr_cnt <= wr_cnt + 1;
            if (is_first_mat) a_mem[idx_i][idx_j] <= wr_data;
            else              b_mem[idx_i][idx_j] <= wr_data;
        end
        if (compute_enable) begin
            cmp_cnt <= cmp_cnt + 1;
            s = 0;
            for (int k = 0; k < int'(match_dim); k++)
                s += int'(a_mem[idx_i][k]) * int'(b_mem[k][idx_j]);
            helper_data <= OW'(s);
        end
        if (wr_enable && compute_enable) overlap_cnt <= overlap_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_job(input int r, input int k, input int c);
        @(negedge clk);
        dim_r = N'(r); dim_k = N'(k); dim_c = N'(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stream(input int n);
        int idx = 0;
        int budget = 0;
        while (idx < n && budget < 500) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = DW'(elem_q[idx]);
            if (in_ready) idx++;
            budget++;
        end
        n_checks++;
        if (idx != n) $display("FAIL stream_accept: got %0d expected %0d elements", idx, n);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input int n_exp);
        int cyc = 0;
        out_ready = 1'b1;
        got_q.delete();
        while (got_q.size() < n_exp && cyc < 2000) begin
            if (out_valid) got_q.push_back(int'($signed(out_data)));
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (got_q.size() != n_exp) $display("FAIL collect_count: got %0d expected %0d results", got_q.size(), n_exp);
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_job(input int r, input int k, input int c);
        start_job(r, k, c);
        stream(r * k + k * c);
        collect(r * c);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({in_ready, wr_enable, compute_enable, is_first_mat, out_valid, busy, err} !== 7'b0)
            $display("FAIL reset_flags: got %b expected 0000000",
                     {in_ready, wr_enable, compute_enable, is_first_mat, out_valid, busy, err});
        else n_pass++;
        n_checks++;
        if ({idx_i, idx_j, match_dim} !== '0)
            $display("FAIL reset_idx: got %h expected 0", {idx_i, idx_j, match_dim});
        else n_pass++;
        n_checks++;
        if (wr_data !== '0 || out_data !== '0)
            $display("FAIL reset_data: got wr=%h out=%h expected 0", wr_data, out_data);
        else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL reset_release: got busy=%b in_ready=%b expected 0", busy, in_ready);
        else n_pass++;
    endtask

    task automatic test_identity();
        int exp_v[4] = '{1, 2, 3, 4};
        int w0 = wr_cnt;
        int c0 = cmp_cnt;
        elem_q = '{1, 0, 0, 1, 1, 2, 3, 4};
        run_job(2, 2, 2);
        for (int i = 0; i < 4; i++) begin
            int g = (i < got_q.size()) ? got_q[i] : 32'h7fffffff;
            n_checks++;
            if (g !== exp_v[i]) $display("FAIL identity_c%0d: got %0d expected %0d", i, g, exp_v[i]);
            else n_pass++;
        end
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL identity_idle: got busy=%b out_valid=%b expected 0", busy, out_valid);
        else n_pass++;
        n_checks++;
        if (match_dim !== 4'd2) $display("FAIL identity_match_dim: got %0d expected 2", match_dim);
        else n_pass++;
        n_checks++;
        if (wr_cnt - w0 != 8 || cmp_cnt - c0 != 4)
            $display("FAIL identity_strobes: got wr=%0d cmp=%0d expected wr=8 cmp=4", wr_cnt - w0, cmp_cnt - c0);
        else n_pass++;
    endtask

    task automatic test_min_extremes();
        int g;
        elem_q = '{-128, 127};
        run_job(1, 1, 1);
        g = (got_q.size() > 0) ? got_q[0] : 32'h7fffffff;
        n_checks++;
        if (g !== -16256) $display("FAIL extremes_c0: got %0d expected -16256", g);
        else n_pass++;
    endtask

    task automatic test_full_size();
        elem_q.delete();
        for (int i = 0; i < 32; i++) elem_q.push_back(127);
        run_job(4, 4, 4);
        for (int i = 0; i < 16; i++) begin
            int g = (i < got_q.size()) ? got_q[i] : 32'h7fffffff;
            n_checks++;
            if (g !== 64516) $display("FAIL full_c%0d: got %0d expected 64516", i, g);
            else n_pass++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL full_idle: got busy=%b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int exp_v[4] = '{19, 22, 43, 50};
        int cyc = 0;
        int c0;
        elem_q = '{1, 2, 3, 4, 5, 6, 7, 8};
        out_ready = 1'b0;
        start_job(2, 2, 2);
        stream(8);
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL bp_first_valid: got %b expected 1", out_valid);
        else n_pass++;
        c0 = cmp_cnt;
        for (int s = 0; s < 5; s++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 20'd19)
                $display("FAIL bp_hold%0d: got valid=%b data=%0d expected valid=1 data=19", s, out_valid, out_data);
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if (cmp_cnt != c0) $display("FAIL bp_no_compute: got %0d expected 0 compute pulses", cmp_cnt - c0);
        else n_pass++;
        collect(4);
        for (int i = 0; i < 4; i++) begin
            int g = (i < got_q.size()) ? got_q[i] : 32'h7fffffff;
            n_checks++;
            if (g !== exp_v[i]) $display("FAIL bp_c%0d: got %0d expected %0d", i, g, exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midjob();
        int exp_v[4] = '{1, 2, 3, 4};
        int w0;
        elem_q = '{1, 2, 3};
        start_job(2, 2, 2);
        stream(3);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, wr_enable, compute_enable, is_first_mat, out_valid, busy, err} !== 7'b0)
            $display("FAIL midreset_flags: got %b expected 0000000",
                     {in_ready, wr_enable, compute_enable, is_first_mat, out_valid, busy, err});
        else n_pass++;
        n_checks++;
        if ({idx_i, idx_j, match_dim} !== '0 || wr_data !== '0 || out_data !== '0)
            $display("FAIL midreset_fields: got idx=%h wr=%h out=%h expected 0", {idx_i, idx_j, match_dim}, wr_data, out_data);
        else n_pass++;
        w0 = wr_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (wr_cnt != w0 || busy !== 1'b0)
            $display("FAIL midreset_quiet: got writes=%0d busy=%b expected 0 0", wr_cnt - w0, busy);
        else n_pass++;
        elem_q = '{1, 0, 0, 1, 1, 2, 3, 4};
        run_job(2, 2, 2);
        for (int i = 0; i < 4; i++) begin
            int g = (i < got_q.size()) ? got_q[i] : 32'h7fffffff;
            n_checks++;
            if (g !== exp_v[i]) $display("FAIL midreset_job_c%0d: got %0d expected %0d", i, g, exp_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_dims();
`ifdef MM_SEQUENCER_DIM_CHECK_EN
        int g;
        start_job(2, 2, 5);
        repeat (2) @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0)
            $display("FAIL dims_over: got err=%b busy=%b expected err=1 busy=0", err, busy);
        else n_pass++;
        start_job(0, 2, 2);
        repeat (2) @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0)
            $display("FAIL dims_zero: got err=%b busy=%b expected err=1 busy=0", err, busy);
        else n_pass++;
        elem_q = '{3, -4};
        start_job(1, 1, 1);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1)
            $display("FAIL dims_clear: got err=%b busy=%b expected err=0 busy=1", err, busy);
        else n_pass++;
        stream(2);
        collect(1);
        g = (got_q.size() > 0) ? got_q[0] : 32'h7fffffff;
        n_checks++;
        if (g !== -12) $display("FAIL dims_job: got %0d expected -12", g);
        else n_pass++;
`else
        start_job(0, 2, 2);
        repeat (3) @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0)
            $display("FAIL dims_zero: got err=%b busy=%b expected err=0 busy=0", err, busy);
        else n_pass++;
        start_job(2, 2, 5);
        repeat (2) @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1)
            $display("FAIL dims_over: got err=%b busy=%b expected err=0 busy=1", err, busy);
        else n_pass++;
        do_reset();
`endif
    endtask

    task automatic test_exclusive();
        n_checks++;
        if (overlap_cnt != 0) $display("FAIL strobe_overlap: got %0d expected 0 overlapping cycles", overlap_cnt);
        else n_pass++;
    endtask

    initial begin
        do_reset();
        test_reset();
        test_identity();
        test_min_extremes();
        test_full_size();
        test_backpressure();
        test_reset_midjob();
        test_dims();
        test_exclusive();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
